// File: rtl/uabc_uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// UABC_UART_PARITY_EN selects the 11-bit frame with an even-parity bit.
package uabc_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

`ifdef UABC_UART_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 3;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`endif

  function automatic int unsigned frame_cycles(int unsigned clk_div);
    return FRAME_BITS * clk_div;
  endfunction

endpackage

// File: rtl/uabc_uart_if.sv
// Byte write port plus serial line and flow-control status of the transmitter.
interface uabc_uart_if;
  import uabc_uart_pkg::*;

  logic                 ena;
  logic [DATA_BITS-1:0] data_in;
  logic                 wr_en;
  logic                 tx;
  logic                 busy;
  logic                 full;

  modport master (
    output ena, data_in, wr_en,
    input  tx, busy, full
  );

  modport slave (
    input  ena, data_in, wr_en,
    output tx, busy, full
  );

endinterface

// File: rtl/uabc_tx_fifo.sv
// Synchronous byte FIFO; depth must be a power of two so pointers wrap naturally.
module uabc_tx_fifo
  import uabc_uart_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // A push is judged against the registered full flag, so it is lost even
  // when a pop frees a slot on the same edge.
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
    full_d = (count_d == CntW'(Depth));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uabc_uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame FSM with fixed baud divisor.
// Define UABC_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module uabc_uart_tx
  import uabc_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 87,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  uabc_uart_if.slave bus
);

  localparam int unsigned    CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]    BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [CntW-1:0]      fifo_count;
  logic                 bit_end;
  logic                 can_start;

  uabc_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_en & bus.ena),
    .pop   (fifo_pop),
    .din   (bus.data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    fifo_pop  = 1'b0;
    bit_end   = (baud_q == BAUD_MAX);
    baud_d    = bit_end ? 16'd0 : baud_q + 16'd1;
    can_start = ~fifo_empty & bus.ena;

    unique case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        if (can_start) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          par_d    = ^fifo_dout;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
`ifdef UABC_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so frames have no idle gap.
        if (bit_end) begin
          if (can_start) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = ^fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so tx is registered with no extra lag.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.full = fifo_full;
  assign bus.busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uabc_uart_tx.sv
// Directed bench for uabc_uart_tx at CLK_DIV=4; adds parity frames when
// UABC_UART_PARITY_EN is defined.
module tb_uabc_uart_tx;
  import uabc_uart_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CYC  = int'(FRAME_BITS) * CLK_DIV;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  uabc_uart_if bus();

  uabc_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return b[idx-1];
`ifdef UABC_UART_PARITY_EN
    if (idx == DATA_BITS + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) step();
    n_checks++;
    if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle c%0d: got tx=%b busy=%b want tx=1 busy=0", i, bus.tx, bus.busy);
      end
    end
  endtask

  task automatic test_single();
    bus.data_in = 8'h55;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got tx=%b busy=%b want tx=1 busy=1", bus.tx, bus.busy);
    end
    for (int j = 0; j < FRAME_CYC; j++) begin
      step();
      n_checks++;
      if (bus.tx !== frame_bit(8'h55, j / CLK_DIV)) begin
        n_fail++;
        $display("FAIL single_tx c%0d: got %b want %b", j, bus.tx, frame_bit(8'h55, j / CLK_DIV));
      end
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last: got %b want 1", bus.busy); end
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.busy);
    end
  endtask

  // Six writes on consecutive edges: 0x06 hits a full FIFO and is dropped.
  task automatic test_back_to_back();
    int         idx;
    logic [7:0] b;
    logic       exp_full;
    for (int i = 0; i < 6; i++) begin
      bus.data_in = 8'(i + 1);
      bus.wr_en   = 1'b1;
      step();
      exp_full = (i >= 4);
      n_checks++;
      if (bus.full !== exp_full) begin
        n_fail++;
        $display("FAIL ovf_full w%0d: got %b want %b", i + 1, bus.full, exp_full);
      end
      if (i >= 1) begin
        idx = i - 1;
        n_checks++;
        if (bus.tx !== frame_bit(8'h01, idx / CLK_DIV)) begin
          n_fail++;
          $display("FAIL ovf_tx c%0d: got %b want %b", idx, bus.tx, frame_bit(8'h01, idx / CLK_DIV));
        end
      end
    end
    bus.wr_en = 1'b0;
    for (int cyc = 7; cyc < 2 + 5 * FRAME_CYC; cyc++) begin
      step();
      idx = cyc - 2;
      b   = 8'(idx / FRAME_CYC + 1);
      n_checks++;
      if (bus.tx !== frame_bit(b, (idx % FRAME_CYC) / CLK_DIV)) begin
        n_fail++;
        $display("FAIL ovf_tx c%0d: got %b want %b", idx, bus.tx,
                 frame_bit(b, (idx % FRAME_CYC) / CLK_DIV));
      end
      if (cyc == 1 + FRAME_CYC) begin
        n_checks++;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_hold: got %b want 1", bus.full); end
      end
      if (cyc == 2 + FRAME_CYC) begin
        n_checks++;
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_clear: got %b want 0", bus.full); end
      end
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_done: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.busy);
    end
  endtask

  task automatic test_disable();
    bus.data_in = 8'hA3;
    bus.wr_en   = 1'b1;
    step();
    for (int j = 0; j < FRAME_CYC; j++) begin
      bus.wr_en   = (j == 3);
      bus.data_in = 8'h5C;
      if (j == 14) bus.ena = 1'b0;
      step();
      n_checks++;
      if (bus.tx !== frame_bit(8'hA3, j / CLK_DIV)) begin
        n_fail++;
        $display("FAIL dis_tx c%0d: got %b want %b", j, bus.tx, frame_bit(8'hA3, j / CLK_DIV));
      end
    end
    // Parked with 0x5C queued; a write while disabled must be ignored.
    for (int k = 0; k < 8; k++) begin
      bus.wr_en   = (k == 2);
      bus.data_in = 8'hFF;
      step();
      n_checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL dis_park c%0d: got tx=%b busy=%b want tx=1 busy=1", k, bus.tx, bus.busy);
      end
    end
    bus.wr_en = 1'b0;
    bus.ena   = 1'b1;
    for (int j = 0; j < FRAME_CYC; j++) begin
      step();
      n_checks++;
      if (bus.tx !== frame_bit(8'h5C, j / CLK_DIV)) begin
        n_fail++;
        $display("FAIL dis_resume_tx c%0d: got %b want %b", j, bus.tx, frame_bit(8'h5C, j / CLK_DIV));
      end
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dis_done_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_mid_reset();
    bus.data_in = 8'h00;
    bus.wr_en   = 1'b1;
    step();
    bus.data_in = 8'h11;
    step();
    bus.wr_en = 1'b0;
    repeat (6) step();
    n_checks++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_pre: got tx=%b busy=%b want tx=0 busy=1", bus.tx, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL mrst_async_tx: got %b want 1", bus.tx); end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_async_flags: got busy=%b full=%b want 0 0", bus.busy, bus.full);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      step();
      n_checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mrst_after c%0d: got tx=%b busy=%b want tx=1 busy=0", i, bus.tx, bus.busy);
      end
    end
  endtask

`ifdef UABC_UART_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals [2];
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int v = 0; v < 2; v++) begin
      bus.data_in = vals[v];
      bus.wr_en   = 1'b1;
      step();
      bus.wr_en = 1'b0;
      for (int j = 0; j < 44; j++) begin
        step();
        n_checks++;
        if (bus.tx !== frame_bit(vals[v], j / CLK_DIV)) begin
          n_fail++;
          $display("FAIL par_tx %h c%0d: got %b want %b", vals[v], j, bus.tx,
                   frame_bit(vals[v], j / CLK_DIV));
        end
        if (j == 36) begin
          n_checks++;
          if (bus.tx !== (v == 0)) begin
            n_fail++;
            $display("FAIL par_bit %h: got %b want %b", vals[v], bus.tx, (v == 0));
          end
        end
      end
      step();
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL par_len %h: got busy=%b want 0", vals[v], bus.busy); end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_disable();
    test_mid_reset();
`ifdef UABC_UART_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uabc_uart_tx.md
# uabc_uart_tx

Buffered 8N1 UART transmitter for the `tt_um_uabc_test2024_AGV` user project. It sits between the dedicated inputs and output pin 0:
- upstream logic strobes bytes from `ui_in` into a 4-entry FIFO;
- the block serializes them onto `tx` at a fixed divisor;
- `busy` and `full` are exported on `uo_out` so the cocotb bench can observe flow control.

## Interface
- `CLK_DIV`, default 87 — clock cycles per UART bit, range 2..65535 (87 ≈ 115200 baud at 10 MHz).
- `FIFO_DEPTH`, default 4 — byte FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design-select; when low, no new frame starts and writes are ignored.
- `data_in`  in  8  byte to queue.
- `wr_en`  in  1  single-cycle write strobe; accepted when `full`=0 and `ena`=1.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries, registered.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `full`=0;
  - FIFO empty, pointers 0;
  - bit counter 0, baud counter 0;
  - state IDLE.
- FIFO:
  - A write is accepted at an edge where `wr_en`=1, `ena`=1 and registered `full`=0.
  - Writes while `full`=1 are silently dropped, even if a pop happens on the same edge.
  - Simultaneous accepted write and pop leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: `tx`=1. If the FIFO is non-empty and `ena`=1, pop the head into the shift register, go to START, and clear the baud counter.
  - START: `tx`=0 for `CLK_DIV` cycles, then go to DATA with the bit index at 0.
  - DATA: `tx` = shift[0], LSB first. Shift right every `CLK_DIV` cycles; after bit 7, go to STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles. At the end, if the FIFO is non-empty and `ena`=1, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..`CLK_DIV`-1. The bit boundary occurs when it equals `CLK_DIV`-1; the counter then wraps to 0.
- `ena` falling mid-frame: the current frame completes normally; the FSM then parks in IDLE with the FIFO contents retained.
- `rst_n` asserted mid-frame:
  - `tx` returns to 1 immediately (asynchronously);
  - FIFO contents are discarded;
  - no partial frame resumes after release.
- `busy` is combinational from state and FIFO count: (state≠IDLE) or (count≠0).

## Timing
- Write latency: byte accepted at edge N into an idle, empty block → pop at edge N+1 → `tx` low from edge N+1.
- Frame length: 10×`CLK_DIV` cycles (11×`CLK_DIV` with parity).
- Back-to-back frames: the stop bit of frame k is immediately followed by the start bit of frame k+1.
- `full` updates on the edge after the write that fills the FIFO.
- `full` clears on the edge of the pop that frees an entry.

## Configuration
- `UABC_UART_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP;
  - `tx` = XOR of the 8 data bits (even parity) for `CLK_DIV` cycles.
- Not defined:
  - PARITY state is absent;
  - frame is exactly 10 bits (8N1).

## Structure
- Package `uabc_uart_pkg`:
  - state enum (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - `DATA_BITS`=8;
  - frame-length localparams.
- Sub-module `uabc_tx_fifo`:
  - synchronous FIFO, parameterized depth and width;
  - ports: push, pop, din, dout, full, empty, count.
- Top `uabc_uart_tx` contains the FSM, baud counter and shift register.

## Test plan
All scenarios use `CLK_DIV`=4.
- Reset check: hold `rst_n`=0 for 3 cycles → `tx`=1, `busy`=0, `full`=0; release → `tx` stays 1 with no writes.
- Single byte: write 0x55 → `tx` = 0 then 1,0,1,0,1,0,1,0 then 1, each level held 4 cycles; `busy` deasserts exactly 40 cycles after the pop edge.
- Overflow: 6 consecutive writes 0x01..0x06 starting in idle → first pops at the next edge; `full`=1 after the 5th write; 0x06 dropped; line carries 0x01..0x05 back-to-back with no idle cycles (200 cycles total).
- Disable: queue 0xA3, drop `ena` at the 15th cycle of the frame → the 0xA3 frame completes; a second queued byte does not start until `ena`=1.
- Mid-frame reset: pulse `rst_n` low during a DATA bit → `tx`=1 asynchronously; FIFO empty; `busy`=0 after release.
- Parity build (`UABC_UART_PARITY_EN`): write 0x07 → parity bit 1; write 0x03 → parity bit 0; each frame is 44 cycles.
